// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with HI/LO result registers.
// One radix-2 step per clock (shift-add multiply, restoring divide) on operand
// magnitudes, with the sign fixed up when HI/LO are written on the final step.
module muldiv_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] porta,
    input  logic [31:0] portb,
    input  logic [1:0]  op,
    input  logic        start,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        divzero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_opnd;      // multiplicand or divisor magnitude
    logic [31:0] r_work_hi;   // partial product high half / partial remainder
    logic [31:0] r_work_lo;   // multiplier bits / dividend bits becoming quotient
    logic        r_neg_q;     // negate product or quotient at completion
    logic        r_neg_r;     // negate remainder at completion
    logic        r_divz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_divz_start;
    logic        w_finish;
    logic        w_mt_ok;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_iter_hi;
    logic [31:0] w_iter_lo;
    logic [63:0] w_prod;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Operand magnitudes for launch; op[0]=1 selects the unsigned variants
    assign w_signed = ~op[0];
    assign w_mag_a  = (w_signed && porta[31]) ? -porta : porta;
    assign w_mag_b  = (w_signed && portb[31]) ? -portb : portb;

    // Single radix-2 step of multiply or divide, plus final sign correction
    assign w_mul_sum   = {1'b0, r_work_hi} + {1'b0, (r_work_lo[0] ? r_opnd : 32'd0)};
    assign w_div_shift = {r_work_hi, r_work_lo[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_prod      = {w_iter_hi, w_iter_lo};

    always_comb begin
        w_iter_hi = w_mul_sum[32:1];
        w_iter_lo = {w_mul_sum[0], r_work_lo[31:1]};
        w_res_hi  = w_prod[63:32];
        w_res_lo  = w_prod[31:0];
        if (r_op[1]) begin
            // The trial remainder is always below 2^32 when it is kept
            w_iter_hi = w_div_ge ? (w_div_shift[31:0] - r_opnd) : w_div_shift[31:0];
            w_iter_lo = {r_work_lo[30:0], w_div_ge};
            w_res_lo  = r_neg_q ? -w_iter_lo : w_iter_lo;
            w_res_hi  = r_neg_r ? -w_iter_hi : w_iter_hi;
        end else if (r_neg_q) begin
            {w_res_hi, w_res_lo} = -w_prod;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_divz_start = 1'b0;
        w_finish     = 1'b0;
        w_mt_ok      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) begin
                    w_accept = 1'b1;
                    if (op[1] && (portb == 32'd0)) begin
                        w_divz_start = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_CALC;
                    end
                end else begin
                    w_mt_ok      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == 5'd31) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        divzero = done & r_divz;
    end

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: operand capture, iteration, HI/LO writes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= 5'd0;
            r_op      <= 2'd0;
            r_opnd    <= 32'd0;
            r_work_hi <= 32'd0;
            r_work_lo <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_divz    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else if (w_accept) begin
            r_cnt     <= 5'd0;
            r_op      <= op;
            r_divz    <= w_divz_start;
            r_work_hi <= 32'd0;
            r_neg_q   <= w_signed & (porta[31] ^ portb[31]);
            r_neg_r   <= w_signed & porta[31];
            if (op[1]) begin
                r_opnd    <= w_mag_b;
                r_work_lo <= w_mag_a;
            end else begin
                r_opnd    <= w_mag_a;
                r_work_lo <= w_mag_b;
            end
        end else if (r_state == S_CALC) begin
            r_cnt     <= r_cnt + 5'd1;
            r_work_hi <= w_iter_hi;
            r_work_lo <= w_iter_lo;
            r_divz    <= 1'b0;
            if (w_finish) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else begin
            r_divz <= 1'b0;
            if (w_mt_ok && mthi) begin
                r_hi <= wdata;
            end
            if (w_mt_ok && mtlo) begin
                r_lo <= wdata;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
